toggle_stream_decoder: RTL

//  Receive end of the toggle (T flip-flop) line code produced by our T-FF encoders.
//  - Samples the encoder's Q line and recovers T as T[n] = Q[n] ^ Q[n-1].
//  - Hunts for a sync word, then deserialises FRAME_WORDS words of WIDTH bits, MSB first.
//  - Delivers each word on a valid/ready output port and flags any word lost to backpressure.

---
 rtl/toggle_codec_pkg.sv | 5 +
 rtl/toggle_bit_decoder.sv | 19 +
 rtl/toggle_stream_decoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/toggle_codec_pkg.sv
// Shared types and constants for the toggle (T flip-flop) line-code receive path.
package toggle_codec_pkg;
   typedef enum logic {ST_HUNT, ST_DATA} state_t;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/toggle_bit_decoder.sv
// Recovers the toggle bit from the sampled Q line: b = Q[n] ^ Q[n-1].
module toggle_bit_decoder (
   input  logic clk,
   input  logic reset,
   input  logic q_in,
   input  logic q_en,
   output logic b,
   output logic b_valid
);
   logic q_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_prev <= 1'b0;
      else if (q_en) q_prev <= q_in;
   end

   assign b       = q_in ^ q_prev;
   assign b_valid = q_en;
endmodule

// File: rtl/toggle_stream_decoder.sv
// Toggle line-code receiver: sync hunt, MSB-first word deserialiser and valid/ready output.
module toggle_stream_decoder
   import toggle_codec_pkg::*;
#(
   parameter int unsigned       WIDTH       = 8,
   parameter logic [WIDTH-1:0]  SYNC_WORD   = WIDTH'(SYNC_DEFAULT),
   parameter int unsigned       FRAME_WORDS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             q_in,
   input  logic             q_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_first,
   output logic             dout_last,
   output logic             in_sync,
   output logic             overflow,
   input  logic             ovf_clr
);
   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

   logic             b, b_valid;
   logic [WIDTH-1:0] shift, word;
   state_t           state;
   logic [BW-1:0]    bitcnt;
   logic [WW-1:0]    wordcnt;
   logic             word_done, load;

   toggle_bit_decoder u_bit (
      .clk     (clk),
      .reset   (reset),
      .q_in    (q_in),
      .q_en    (q_en),
      .b       (b),
      .b_valid (b_valid)
   );

   // Candidate window including the bit arriving this cycle; serves both sync match and word capture.
   assign word      = {shift[WIDTH-2:0], b};
   assign word_done = b_valid && (state == ST_DATA) && (bitcnt == BIT_LAST);
   assign load      = word_done && (!dout_valid || dout_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift   <= '0;
         state   <= ST_HUNT;
         bitcnt  <= '0;
         wordcnt <= '0;
         in_sync <= 1'b0;
      end else if (b_valid) begin
         shift <= word;
         case (state)
            ST_HUNT: begin
               if (word == SYNC_WORD) begin
                  state   <= ST_DATA;
                  in_sync <= 1'b1;
                  bitcnt  <= '0;
                  wordcnt <= '0;
               end
            end
            ST_DATA: begin
               if (bitcnt == BIT_LAST) begin
                  bitcnt <= '0;
                  if (wordcnt == WORD_LAST) begin
                     state   <= ST_HUNT;
                     in_sync <= 1'b0;
                     wordcnt <= '0;
                  end else begin
                     wordcnt <= wordcnt + 1'b1;
                  end
               end else begin
                  bitcnt <= bitcnt + 1'b1;
               end
            end
            default: state <= ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_first <= 1'b0;
         dout_last  <= 1'b0;
      end else if (load) begin
         dout       <= word;
         dout_valid <= 1'b1;
         dout_first <= (wordcnt == '0);
         dout_last  <= (wordcnt == WORD_LAST);
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

   // A dropped word outranks a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overflow <= 1'b0;
      else if (word_done && !load) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end
endmodule
